// File: rtl/elevator_pkg.sv
// Shared elevator encodings: floor codes on `state`, travel direction, invalid floor.
package elevator_pkg;
  localparam int unsigned NUM_FLOORS = 3;

  localparam logic [1:0] ST_FLOOR_ENC  = 2'b00;
  localparam logic [1:0] ND_FLOOR_ENC  = 2'b01;
  localparam logic [1:0] RD_FLOOR_ENC  = 2'b10;
  localparam logic [1:0] INVALID_FLOOR = 2'b11;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;
endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for a raw call button followed by a rising-edge detector.
module button_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  logic sync1, sync2, sync2_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  // A button held through reset release still shows a 0->1 edge here.
  assign press = sync2 & ~sync2_d;
endmodule

// File: rtl/call_registrar.sv
// Call request LEDs for a three-floor car plus the registered travel direction / target.
module call_registrar
  import elevator_pkg::*;
#(
  parameter logic [1:0] ST_FLOOR = ST_FLOOR_ENC,
  parameter logic [1:0] ND_FLOOR = ND_FLOOR_ENC,
  parameter logic [1:0] RD_FLOOR = RD_FLOOR_ENC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic       st_button,
  input  logic       nd_button,
  input  logic       rd_button,
  input  logic       open_door,
  output logic       st_led,
  output logic       nd_led,
  output logic       rd_led,
  output logic [1:0] target_floor,
  output logic       target_valid,
  output logic [1:0] dir
);
  logic [NUM_FLOORS-1:0]       btn, press, clr, led_q;
  logic [NUM_FLOORS-1:0][1:0]  floor_enc;
  logic [1:0]                  cur_idx, lo_above, hi_below;
  logic                        cur_valid, any_above, any_below;
  dir_e                        dir_q;

  assign btn       = {rd_button, nd_button, st_button};
  assign floor_enc = {RD_FLOOR, ND_FLOOR, ST_FLOOR};

  button_sync_edge u_btn [NUM_FLOORS-1:0] (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  always_comb begin
    cur_valid = 1'b0;
    cur_idx   = 2'd0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (state != INVALID_FLOOR && state == floor_enc[i]) begin
        cur_valid = 1'b1;
        cur_idx   = 2'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++)
      clr[i] = open_door & cur_valid & (cur_idx == 2'(i));
  end

  // Clear beats a same-cycle set, so a press at an open door is absorbed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_q <= '0;
    else     led_q <= (led_q | press) & ~clr;
  end

  assign {rd_led, nd_led, st_led} = led_q;

  // Scan order makes the last hit the nearest floor on each side.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    lo_above  = ST_FLOOR;
    hi_below  = ST_FLOOR;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (led_q[i] && 2'(i) > cur_idx) begin
        any_above = 1'b1;
        lo_above  = floor_enc[i];
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (led_q[i] && 2'(i) < cur_idx) begin
        any_below = 1'b1;
        hi_below  = floor_enc[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q        <= DIR_IDLE;
      target_floor <= ST_FLOOR;
      target_valid <= 1'b0;
    end else if (cur_valid) begin
      case (dir_q)
        DIR_IDLE, DIR_UP: begin
          if (any_above) begin
            dir_q        <= DIR_UP;
            target_floor <= lo_above;
            target_valid <= 1'b1;
          end else if (any_below) begin
            dir_q        <= DIR_DOWN;
            target_floor <= hi_below;
            target_valid <= 1'b1;
          end else begin
            dir_q        <= DIR_IDLE;
            target_valid <= 1'b0;
          end
        end
        DIR_DOWN: begin
          if (any_below) begin
            dir_q        <= DIR_DOWN;
            target_floor <= hi_below;
            target_valid <= 1'b1;
          end else if (any_above) begin
            dir_q        <= DIR_UP;
            target_floor <= lo_above;
            target_valid <= 1'b1;
          end else begin
            dir_q        <= DIR_IDLE;
            target_valid <= 1'b0;
          end
        end
        default: begin
          dir_q        <= DIR_IDLE;
          target_valid <= 1'b0;
        end
      endcase
    end
  end

  assign dir = dir_q;
endmodule

// File: tb/tb_call_registrar.sv
// Scenario bench for call_registrar: expected output snapshots queued per step, compared after the edge.
module tb_call_registrar;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       st_button, nd_button, rd_button, open_door;
  logic       st_led, nd_led, rd_led, target_valid;
  logic [1:0] target_floor, dir;

  localparam logic [1:0] IDLE = 2'b00, UP = 2'b01, DOWN = 2'b10;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  call_registrar dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .st_button    (st_button),
    .nd_button    (nd_button),
    .rd_button    (rd_button),
    .open_door    (open_door),
    .st_led       (st_led),
    .nd_led       (nd_led),
    .rd_led       (rd_led),
    .target_floor (target_floor),
    .target_valid (target_valid),
    .dir          (dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs{leds,dir,tgt,tv}=%b exp=%b", tag, obs, exp);
    end
  endtask

  // leds packed {rd,nd,st}
  task automatic expect_out(input string tag, input logic [2:0] leds, input logic [1:0] d,
                            input logic [1:0] t);
    sb_t e;
    e.tag = tag;
    e.exp = {leds, d, t, (d != IDLE)};
    sb_q.push_back(e);
  endtask

  task automatic score();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.tag, {rd_led, nd_led, st_led, dir, target_floor, target_valid}, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic [2:0] leds, input logic [1:0] d,
                          input logic [1:0] t);
    expect_out(tag, leds, d, t);
    tick();
    score();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; state = 2'b00; open_door = 1'b0;
    st_button = 1'b0; nd_button = 1'b0; rd_button = 1'b0;
    tick();
    expect_out("in_reset", 3'b000, IDLE, 2'b00); score();
    tick();
    rst = 1'b0;
    tick_chk("reset_idle", 3'b000, IDLE, 2'b00);

    // floor 3 call from floor 1, held for three cycles
    rd_button = 1'b1;
    tick_chk("rd_k", 3'b000, IDLE, 2'b00);
    tick_chk("rd_k1", 3'b000, IDLE, 2'b00);
    tick_chk("rd_k2_led", 3'b100, IDLE, 2'b00);
    rd_button = 1'b0;
    tick_chk("rd_k3_dir", 3'b100, UP, 2'b10);
    tick_chk("rd_steady", 3'b100, UP, 2'b10);

    // both ends pending from floor 2: up wins, then service at floor 3
    do_reset();
    state = 2'b01; st_button = 1'b1; rd_button = 1'b1;
    tick();
    st_button = 1'b0; rd_button = 1'b0;
    tick_chk("both_k1", 3'b000, IDLE, 2'b00);
    tick_chk("both_led", 3'b101, IDLE, 2'b00);
    tick_chk("both_up", 3'b101, UP, 2'b10);
    state = 2'b10; open_door = 1'b1;
    tick_chk("od_cycle1", 3'b001, DOWN, 2'b00);
    tick_chk("od_cycle2", 3'b001, DOWN, 2'b00);
    open_door = 1'b0;
    tick_chk("od_after", 3'b001, DOWN, 2'b00);

    // press at open door is absorbed
    state = 2'b01;
    do_reset();
    open_door = 1'b1; nd_button = 1'b1;
    tick();
    nd_button = 1'b0;
    for (int i = 0; i < 4; i++) tick_chk($sformatf("absorb_%0d", i), 3'b000, IDLE, 2'b00);
    open_door = 1'b0;
    tick_chk("absorb_after", 3'b000, IDLE, 2'b00);

    // invalid floor: no clear, direction holds, presses still register
    do_reset();
    st_button = 1'b1;
    tick();
    st_button = 1'b0;
    tick_chk("st_k1", 3'b000, IDLE, 2'b00);
    tick_chk("st_led", 3'b001, IDLE, 2'b00);
    tick_chk("st_down", 3'b001, DOWN, 2'b00);
    state = 2'b11; open_door = 1'b1; rd_button = 1'b1;
    tick_chk("inv_k", 3'b001, DOWN, 2'b00);
    rd_button = 1'b0;
    tick_chk("inv_k1", 3'b001, DOWN, 2'b00);
    tick_chk("inv_set", 3'b101, DOWN, 2'b00);
    tick_chk("inv_hold", 3'b101, DOWN, 2'b00);
    open_door = 1'b0;

    // button held across reset release registers exactly once
    rst = 1'b1; state = 2'b00; nd_button = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick_chk("held_k", 3'b000, IDLE, 2'b00);
    tick_chk("held_k1", 3'b000, IDLE, 2'b00);
    tick_chk("held_led", 3'b010, IDLE, 2'b00);
    tick_chk("held_up", 3'b010, UP, 2'b01);
    state = 2'b01; open_door = 1'b1;
    tick_chk("held_clr", 3'b000, IDLE, 2'b01);
    open_door = 1'b0;
    for (int i = 0; i < 3; i++) tick_chk($sformatf("held_once_%0d", i), 3'b000, IDLE, 2'b01);
    nd_button = 1'b0;

    // asynchronous reset mid-cycle
    do_reset();
    state = 2'b00; rd_button = 1'b1;
    tick();
    rd_button = 1'b0;
    tick_chk("pre_k1", 3'b000, IDLE, 2'b00);
    tick_chk("pre_led", 3'b100, IDLE, 2'b00);
    tick_chk("pre_up", 3'b100, UP, 2'b10);
    #2;
    rst = 1'b1;
    expect_out("async_rst", 3'b000, IDLE, 2'b00);
    #1;
    score();
    tick();
    rst = 1'b0;
    tick_chk("post_rst", 3'b000, IDLE, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/call_registrar.md
# call_registrar

Registers hall/car call requests for the three-floor elevator and drives the request LEDs consumed by `door_status`. It also clears each LED once `door_status` signals service at that floor via `open_door`. From the pending set it derives a registered travel direction and target floor for the motion controller, so `door_status` services requests and this block produces and retires them.

## Interface
Parameters:
- `ST_FLOOR`, default 2'b00: encoding of floor 1 on `state`
- `ND_FLOOR`, default 2'b01: encoding of floor 2
- `RD_FLOOR`, default 2'b10: encoding of floor 3

Ports:
- `clk`  in  1: single clock; all logic on rising edge
- `rst`  in  1: asynchronous, active-high reset
- `state`  in  2: current car floor; 2'b11 is invalid
- `st_button`, `nd_button`, `rd_button`  in  1 each: raw asynchronous call buttons, active-high
- `open_door`  in  1: from `door_status`; high while the door is open at `state`
- `st_led`, `nd_led`, `rd_led`  out  1 each: pending request per floor
- `target_floor`  out  2: floor the car must travel to next
- `target_valid`  out  1: `target_floor` is meaningful (direction is UP or DOWN)
- `dir`  out  2: IDLE=2'b00, UP=2'b01, DOWN=2'b10

## Operation
- Each button passes through a 2-FF synchronizer and then a rising-edge detector, producing a one-cycle `press` pulse. Holding a button produces exactly one pulse.
- LED set: on a `press` pulse for floor f, the LED for f goes to 1.
- LED clear: while `open_door`=1 and `state` equals floor f, the LED for f goes to 0. A clear in the same cycle as a set for the same floor wins, so pressing at an open door is absorbed.
- When `state`=2'b11, no LED is cleared and direction/target hold their values. Presses still set LEDs.
- Direction FSM, evaluated on the registered LEDs and current `state`:
  - IDLE: if a request exists above the car, go UP. Otherwise, if a request exists below, go DOWN. Otherwise stay in IDLE. A request only at the current floor keeps IDLE, because `door_status` services it.
    - At `ND_FLOOR` with requests both above and below: choose UP.
  - UP: `target_floor` is the lowest pending floor above `state`. If nothing is pending above, go DOWN if anything is pending below, otherwise go IDLE.
  - DOWN: symmetric to UP; `target_floor` is the highest pending floor below `state`.
- `target_valid` equals (`dir` != IDLE). When `target_valid`=0, `target_floor` holds its last value.

## Timing
- Reset values: all LEDs 0, `dir`=IDLE, `target_valid`=0, `target_floor`=`ST_FLOOR`, all synchronizer and edge flops 0.
- A button held across reset release is registered once, as a press, after release.
- Press latency: a button rising before edge k is sampled by sync1 at edge k and sync2 at edge k+1. The LED is high after edge k+2, and `dir`/`target_floor` update after edge k+3.
- Clear latency: with `open_door`=1 and a matching `state` before edge k, the LED is low after edge k. `dir`/`target_floor` reflect the clear after edge k+1.
- A multi-cycle `open_door` holds the matching LED at 0 for its whole duration. A single-cycle `open_door` is sufficient to clear.
- Reset asserted mid-operation immediately forces all reset values; pending requests are lost.

## Structure
- Shared package `elevator_pkg`: the floor encodings (also used by `door_status`), the `dir` encoding, and the invalid-floor constant 2'b11.
- Sub-module `button_sync_edge` (2-FF synchronizer plus rising-edge detector, with asynchronous reset), instantiated three times.
- The LED register bank and the direction FSM stay in the top level.

## Test plan
- Reset, then idle at `ST_FLOOR` → LEDs 000, `dir`=IDLE, `target_valid`=0, `target_floor`=00.
- Car at `ST_FLOOR`; pulse `rd_button` for 3 cycles → `rd_led`=1 after edge k+2; `dir`=UP, `target_floor`=10, `target_valid`=1 after edge k+3; exactly one set while held.
- Car at `ND_FLOOR`; `st_led` and `rd_led` pending, `dir` IDLE → `dir`=UP, `target_floor`=10. Then `state`=10 with a 2-cycle `open_door` → `rd_led`=0, `dir`=DOWN, `target_floor`=00.
- Car at `ND_FLOOR` with `open_door`=1; `nd_button` pressed → `nd_led` stays 0 (clear wins); `dir` stays IDLE.
- `state`=11 with `open_door`=1 and `st_led`=1 → `st_led` stays 1; `dir`/`target_floor` unchanged.
- `rd_led` pending and `dir`=UP; assert `rst` asynchronously mid-cycle → all outputs return to reset values before the next clock edge.
